fetch_push_stage: RTL and testbench



---
 rtl/fetch_push_stage.sv | 144 ++++++++++++++
 tb/tb_fetch_push_stage.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_push_stage.sv
// Fetch push stage: holds one fetch bundle and pushes its lanes into the
// multi-lane write port of the fetch-to-decode FIFO. Lanes the FIFO does not
// take are compacted down to lane 0 and offered again, in program order.
module fetch_push_stage #(
  parameter int unsigned PORT_NUM   = 4,
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned PC_STEP    = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             bundle_valid,
  output logic                             bundle_ready,
  input  logic [ADDR_WIDTH-1:0]            bundle_pc,
  input  logic [PORT_NUM*INST_WIDTH-1:0]   bundle_inst,
  input  logic [PORT_NUM-1:0]              bundle_mask,
  input  logic                             flush,
  output logic [ADDR_WIDTH+INST_WIDTH-1:0] fifo_data_in [PORT_NUM],
  output logic [PORT_NUM-1:0]              fifo_data_in_valid,
  input  logic [PORT_NUM-1:0]              fifo_data_in_enable,
  output logic                             fifo_push,
  input  logic                             fifo_full,
  output logic                             busy,
  output logic [15:0]                      stall_cycles
);

  localparam int unsigned CntW = $clog2(PORT_NUM) + 1;

  logic [ADDR_WIDTH-1:0] slot_pc_q   [PORT_NUM];
  logic [ADDR_WIDTH-1:0] slot_pc_d   [PORT_NUM];
  logic [INST_WIDTH-1:0] slot_inst_q [PORT_NUM];
  logic [INST_WIDTH-1:0] slot_inst_d [PORT_NUM];
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [15:0]           stall_q, stall_d;

  logic [CntW-1:0] accepted;
  logic [CntW-1:0] remain;
  logic [CntW-1:0] n_load;
  logic            acc_run;
  logic            mask_run;
  logic            load;

  // Present held slots to the FIFO.
  always_comb begin
    for (int i = 0; i < int'(PORT_NUM); i++) begin
      fifo_data_in_valid[i] = (CntW'(i) < cnt_q);
      fifo_data_in[i]       = {slot_pc_q[i], slot_inst_q[i]};
    end
    fifo_push    = (cnt_q != '0) && !flush;
    busy         = (cnt_q != '0);
    stall_cycles = stall_q;
  end

  // Lanes taken this cycle: leading run of offered-and-enabled lanes.
  always_comb begin
    accepted = '0;
    acc_run  = 1'b1;
    for (int i = 0; i < int'(PORT_NUM); i++) begin
      if (acc_run && fifo_data_in_valid[i] && fifo_data_in_enable[i]) begin
        accepted = accepted + CntW'(1);
      end else begin
        acc_run = 1'b0;
      end
    end
    if (fifo_full || !fifo_push) accepted = '0;
  end

  // Incoming bundle length: leading run of ones in the mask.
  always_comb begin
    n_load   = '0;
    mask_run = 1'b1;
    for (int i = 0; i < int'(PORT_NUM); i++) begin
      if (mask_run && bundle_mask[i]) begin
        n_load = n_load + CntW'(1);
      end else begin
        mask_run = 1'b0;
      end
    end
  end

  // A new bundle may load in the same cycle the last held lanes drain.
  always_comb begin
    remain       = cnt_q - accepted;
    bundle_ready = rst && !flush && (remain == '0);
    load         = bundle_valid && bundle_ready;
  end

  // Next state: flush beats load, load beats drain.
  always_comb begin
    cnt_d   = cnt_q;
    stall_d = stall_q;
    for (int i = 0; i < int'(PORT_NUM); i++) begin
      slot_pc_d[i]   = slot_pc_q[i];
      slot_inst_d[i] = slot_inst_q[i];
    end

    if (flush) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = n_load;
      for (int i = 0; i < int'(PORT_NUM); i++) begin
        if (CntW'(i) < n_load) begin
          slot_inst_d[i] = bundle_inst[i*INST_WIDTH +: INST_WIDTH];
          slot_pc_d[i]   = bundle_pc + ADDR_WIDTH'(i * PC_STEP);
        end
      end
    end else if (accepted != '0) begin
      cnt_d = remain;
      // Shift the untaken lanes down by the accepted count; upper slots go stale.
      for (int i = 0; i < int'(PORT_NUM); i++) begin
        for (int k = 1; k < int'(PORT_NUM) - i; k++) begin
          if (accepted == CntW'(k)) begin
            slot_pc_d[i]   = slot_pc_q[i+k];
            slot_inst_d[i] = slot_inst_q[i+k];
          end
        end
      end
    end

    if (!flush && (cnt_q != '0) && (accepted == '0) && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      stall_q <= '0;
      for (int i = 0; i < int'(PORT_NUM); i++) begin
        slot_pc_q[i]   <= '0;
        slot_inst_q[i] <= '0;
      end
    end else begin
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      for (int i = 0; i < int'(PORT_NUM); i++) begin
        slot_pc_q[i]   <= slot_pc_d[i];
        slot_inst_q[i] <= slot_inst_d[i];
      end
    end
  end

endmodule

// File: tb/tb_fetch_push_stage.sv
// Directed bench for fetch_push_stage: one task per scenario, inline checks.
module tb_fetch_push_stage;

  logic        clk;
  logic        rst;
  logic        bundle_valid;
  logic        bundle_ready;
  logic [31:0] bundle_pc;
  logic [127:0] bundle_inst;
  logic [3:0]  bundle_mask;
  logic        flush;
  logic [63:0] fifo_data_in [4];
  logic [3:0]  fifo_data_in_valid;
  logic [3:0]  fifo_data_in_enable;
  logic        fifo_push;
  logic        fifo_full;
  logic        busy;
  logic [15:0] stall_cycles;

  int checks;
  int failures;

  fetch_push_stage #(
    .PORT_NUM  (4),
    .INST_WIDTH(32),
    .ADDR_WIDTH(32),
    .PC_STEP   (4)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .bundle_valid       (bundle_valid),
    .bundle_ready       (bundle_ready),
    .bundle_pc          (bundle_pc),
    .bundle_inst        (bundle_inst),
    .bundle_mask        (bundle_mask),
    .flush              (flush),
    .fifo_data_in       (fifo_data_in),
    .fifo_data_in_valid (fifo_data_in_valid),
    .fifo_data_in_enable(fifo_data_in_enable),
    .fifo_push          (fifo_push),
    .fifo_full          (fifo_full),
    .busy               (busy),
    .stall_cycles       (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge; inputs are then changed 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (fifo_push !== 1'b0) begin
      failures++; $display("FAIL reset_push got=%0h exp=0", fifo_push);
    end
    checks++;
    if (fifo_data_in_valid !== 4'b0000) begin
      failures++; $display("FAIL reset_valid got=%b exp=0000", fifo_data_in_valid);
    end
    checks++;
    if (busy !== 1'b0 || bundle_ready !== 1'b0) begin
      failures++; $display("FAIL reset_busy_ready got=%b%b exp=00", busy, bundle_ready);
    end
    checks++;
    if (stall_cycles !== 16'd0) begin
      failures++; $display("FAIL reset_stall got=%0d exp=0", stall_cycles);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    fifo_data_in_enable = 4'b1111;
    bundle_valid = 1'b1;
    bundle_mask  = 4'b1111;
    bundle_pc    = 32'h1000;
    bundle_inst  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    #1;
    checks++;
    if (bundle_ready !== 1'b1) begin
      failures++; $display("FAIL b2b_ready_idle got=%0h exp=1", bundle_ready);
    end
    step();
    bundle_pc   = 32'h2000;
    bundle_inst = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    #1;
    checks++;
    if (fifo_push !== 1'b1 || fifo_data_in_valid !== 4'b1111 || bundle_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first push=%0h valid=%b ready=%0h exp push=1 valid=1111 ready=1",
               fifo_push, fifo_data_in_valid, bundle_ready);
    end
    checks++;
    if (fifo_data_in[0] !== {32'h1000, 32'hA0} || fifo_data_in[3] !== {32'h100C, 32'hA3}) begin
      failures++;
      $display("FAIL b2b_data_a got=%h/%h exp=%h/%h", fifo_data_in[0], fifo_data_in[3],
               {32'h1000, 32'hA0}, {32'h100C, 32'hA3});
    end
    step();
    bundle_valid = 1'b0;
    #1;
    checks++;
    if (fifo_data_in[0] !== {32'h2000, 32'hB0} || fifo_data_in[2] !== {32'h2008, 32'hB2}) begin
      failures++;
      $display("FAIL b2b_data_b got=%h/%h exp=%h/%h", fifo_data_in[0], fifo_data_in[2],
               {32'h2000, 32'hB0}, {32'h2008, 32'hB2});
    end
    checks++;
    if (bundle_ready !== 1'b1) begin
      failures++; $display("FAIL b2b_ready_b got=%0h exp=1", bundle_ready);
    end
    step();
    checks++;
    if (busy !== 1'b0 || stall_cycles !== 16'd0) begin
      failures++; $display("FAIL b2b_done busy=%0h stall=%0d exp busy=0 stall=0", busy, stall_cycles);
    end
  endtask

  task automatic test_partial();
    fifo_data_in_enable = 4'b0011;
    bundle_valid = 1'b1;
    bundle_mask  = 4'b1111;
    bundle_pc    = 32'h3000;
    bundle_inst  = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    step();
    bundle_valid = 1'b0;
    #1;
    checks++;
    if (bundle_ready !== 1'b0 || fifo_data_in_valid !== 4'b1111) begin
      failures++;
      $display("FAIL partial_first ready=%0h valid=%b exp ready=0 valid=1111",
               bundle_ready, fifo_data_in_valid);
    end
    step();
    fifo_data_in_enable = 4'b1111;
    #1;
    checks++;
    if (fifo_data_in[0] !== {32'h3008, 32'hC2} || fifo_data_in[1] !== {32'h300C, 32'hC3}) begin
      failures++;
      $display("FAIL partial_compact got=%h/%h exp=%h/%h", fifo_data_in[0], fifo_data_in[1],
               {32'h3008, 32'hC2}, {32'h300C, 32'hC3});
    end
    checks++;
    if (fifo_data_in_valid !== 4'b0011 || bundle_ready !== 1'b1) begin
      failures++;
      $display("FAIL partial_second valid=%b ready=%0h exp valid=0011 ready=1",
               fifo_data_in_valid, bundle_ready);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL partial_done busy=%0h exp=0", busy);
    end
  endtask

  task automatic test_full_stall();
    fifo_full    = 1'b1;
    bundle_valid = 1'b1;
    bundle_mask  = 4'b0111;
    bundle_pc    = 32'h4000;
    bundle_inst  = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    step();
    bundle_valid = 1'b0;
    for (int c = 0; c < 5; c++) step();
    checks++;
    if (fifo_data_in_valid !== 4'b0111 || stall_cycles !== 16'd5 || bundle_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_hold valid=%b stall=%0d ready=%0h exp valid=0111 stall=5 ready=0",
               fifo_data_in_valid, stall_cycles, bundle_ready);
    end
    fifo_full = 1'b0;
    #1;
    checks++;
    if (bundle_ready !== 1'b1 || fifo_push !== 1'b1 || fifo_data_in[2] !== {32'h4008, 32'hD2}) begin
      failures++;
      $display("FAIL full_release ready=%0h push=%0h d2=%h exp ready=1 push=1 d2=%h",
               bundle_ready, fifo_push, fifo_data_in[2], {32'h4008, 32'hD2});
    end
    step();
    checks++;
    if (busy !== 1'b0 || stall_cycles !== 16'd5) begin
      failures++; $display("FAIL full_done busy=%0h stall=%0d exp busy=0 stall=5", busy, stall_cycles);
    end
  endtask

  task automatic test_mask_wrap();
    bundle_valid = 1'b1;
    bundle_mask  = 4'b1011;
    bundle_pc    = 32'hFFFF_FFF8;
    bundle_inst  = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
    step();
    bundle_valid = 1'b0;
    #1;
    checks++;
    if (fifo_data_in_valid !== 4'b0011) begin
      failures++; $display("FAIL mask_len valid=%b exp=0011", fifo_data_in_valid);
    end
    checks++;
    if (fifo_data_in[0] !== {32'hFFFF_FFF8, 32'hE0} ||
        fifo_data_in[1] !== {32'hFFFF_FFFC, 32'hE1}) begin
      failures++;
      $display("FAIL mask_wrap_pc got=%h/%h exp=%h/%h", fifo_data_in[0], fifo_data_in[1],
               {32'hFFFF_FFF8, 32'hE0}, {32'hFFFF_FFFC, 32'hE1});
    end
    step();
    bundle_valid = 1'b1;
    bundle_mask  = 4'b0000;
    bundle_pc    = 32'h0;
    #1;
    checks++;
    if (bundle_ready !== 1'b1) begin
      failures++; $display("FAIL mask_zero_ready got=%0h exp=1", bundle_ready);
    end
    step();
    bundle_valid = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || fifo_data_in_valid !== 4'b0000) begin
      failures++;
      $display("FAIL mask_zero_cnt busy=%0h valid=%b exp busy=0 valid=0000", busy, fifo_data_in_valid);
    end
  endtask

  task automatic test_flush();
    bundle_valid = 1'b1;
    bundle_mask  = 4'b0011;
    bundle_pc    = 32'h5000;
    bundle_inst  = {32'hF3, 32'hF2, 32'hF1, 32'hF0};
    step();
    flush        = 1'b1;
    bundle_pc    = 32'h6000;
    bundle_mask  = 4'b1111;
    bundle_inst  = {32'h63, 32'h62, 32'h61, 32'h60};
    #1;
    checks++;
    if (bundle_ready !== 1'b0 || fifo_push !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL flush_cycle ready=%0h push=%0h busy=%0h exp ready=0 push=0 busy=1",
               bundle_ready, fifo_push, busy);
    end
    step();
    flush = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || fifo_data_in_valid !== 4'b0000 || bundle_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_after busy=%0h valid=%b ready=%0h exp busy=0 valid=0000 ready=1",
               busy, fifo_data_in_valid, bundle_ready);
    end
    step();
    bundle_valid = 1'b0;
    #1;
    checks++;
    if (fifo_data_in_valid !== 4'b1111 || fifo_data_in[0] !== {32'h6000, 32'h60}) begin
      failures++;
      $display("FAIL flush_reload valid=%b d0=%h exp valid=1111 d0=%h",
               fifo_data_in_valid, fifo_data_in[0], {32'h6000, 32'h60});
    end
    step();
    checks++;
    if (busy !== 1'b0 || stall_cycles !== 16'd5) begin
      failures++; $display("FAIL flush_done busy=%0h stall=%0d exp busy=0 stall=5", busy, stall_cycles);
    end
  endtask

  task automatic test_async_reset();
    bundle_valid = 1'b1;
    bundle_mask  = 4'b1111;
    bundle_pc    = 32'h7000;
    bundle_inst  = {32'h73, 32'h72, 32'h71, 32'h70};
    step();
    bundle_valid = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1 || fifo_data_in_valid !== 4'b1111) begin
      failures++;
      $display("FAIL arst_loaded busy=%0h valid=%b exp busy=1 valid=1111", busy, fifo_data_in_valid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (fifo_push !== 1'b0 || busy !== 1'b0 || fifo_data_in_valid !== 4'b0000) begin
      failures++;
      $display("FAIL arst_drop push=%0h busy=%0h valid=%b exp 0 0 0000",
               fifo_push, busy, fifo_data_in_valid);
    end
    checks++;
    if (stall_cycles !== 16'd0 || bundle_ready !== 1'b0) begin
      failures++;
      $display("FAIL arst_stall stall=%0d ready=%0h exp stall=0 ready=0", stall_cycles, bundle_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bundle_ready !== 1'b1 || stall_cycles !== 16'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL arst_release ready=%0h stall=%0d busy=%0h exp ready=1 stall=0 busy=0",
               bundle_ready, stall_cycles, busy);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst                 = 1'b0;
    bundle_valid        = 1'b0;
    bundle_pc           = '0;
    bundle_inst         = '0;
    bundle_mask         = '0;
    flush               = 1'b0;
    fifo_data_in_enable = 4'b1111;
    fifo_full           = 1'b0;

    test_reset();
    test_back_to_back();
    test_partial();
    test_full_stall();
    test_mask_wrap();
    test_flush();
    test_async_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
